serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_pkg.sv | 35 +++
 rtl/serial_tx_fifo.sv | 65 ++++++
 rtl/serial_frame_tx.sv | 190 +++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter.
// A frame is 11 bits: start (0), data[7] down to data[0], odd parity, stop (1).
// The frame vector used by the transmitter holds bit b0 at index 0, so it is
// shifted out from the LSB end.
package serial_frame_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BIT_LO,
        BIT_HI,
        GAP
    } tx_state_e;

    // Parity bit that makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Index 0 is the start bit; data goes out MSB first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        logic [FRAME_BITS-1:0] frame;
        frame[0] = START_BIT;
        for (int i = 0; i < 8; i++) begin
            frame[i+1] = data[7-i];
        end
        frame[9]  = odd_parity(data);
        frame[10] = STOP_BIT;
        return frame;
    endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous byte queue placed in front of the frame transmitter.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the queue)
//   push/wdata write one entry; ignored while full
//   pop/rdata  rdata shows the oldest entry; pop removes it; ignored while empty
//   full/empty occupancy flags from the registered count
//   full_next  full flag as it will be after the current edge
// DEPTH must be a power of two so the pointers wrap naturally.
module serial_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             full_next
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    assign full_next = (count_d == DEPTH_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Host-side transmitter for the 11-bit serial frame (start, 8 data MSB first,
// odd parity, stop). Bytes arrive on a valid/ready handshake; SCLK is divided
// from CLK and SDATA changes together with the SCLK falling edge, so a receiver
// sampling on SCLK rising edges recovers the byte.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   TX_DATA    byte to send, sampled at acceptance
//   TX_VALID   TX_DATA valid
//   TX_READY   a byte can be accepted this cycle
//   SCLK       serial clock, idle high
//   SDATA      serial data, idle high
//   BUSY       frame or inter-frame gap in progress
//   DONE       one-cycle pulse after the stop bit
// Build option: define TX_FIFO_EN to put a FIFO_DEPTH-entry byte queue in front
// of the frame FSM; TX_READY then means "queue not full".
// All outputs are registered from the FSM state, so the pins lag the state by
// one cycle; TX_READY is registered from the next state so it drops in the
// cycle right after acceptance.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_GAP  = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       SCLK,
    output logic       SDATA,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned HALF_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_CYC = FRAME_GAP * 2 * CLK_DIV;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_BITS);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    if (CLK_DIV < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("serial_frame_tx: CLK_DIV must be >= 1, FIFO_DEPTH a power of two >= 2");
    end

    tx_state_e             state_q, state_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  end_q, end_d;

    logic sclk_q, sclk_d, sdata_q, sdata_d, busy_q, busy_d;
    logic done_q, done_d, ready_q, ready_d;

    logic       start;
    logic [7:0] start_data;

`ifdef TX_FIFO_EN
    logic       fifo_full, fifo_empty, fifo_full_next;
    logic [7:0] fifo_rdata;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (TX_VALID & ready_q & ~fifo_full),
        .wdata     (TX_DATA),
        .pop       (start),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .full_next (fifo_full_next)
    );

    assign start      = (state_q == IDLE) & ~fifo_empty;
    assign start_data = fifo_rdata;
`else
    assign start      = (state_q == IDLE) & TX_VALID & ready_q;
    assign start_data = TX_DATA;
`endif

    // State register and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            half_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            frame_q <= '1;
            end_q   <= 1'b0;
            sclk_q  <= 1'b1;
            sdata_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            end_q   <= end_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        end_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BIT_LO;
                    half_d  = '0;
                    bit_d   = '0;
                    frame_d = build_frame(start_data);
                end
            end
            BIT_LO: begin
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    state_d = BIT_HI;
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end
            BIT_HI: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (bit_q == BIT_LAST) begin
                        end_d   = 1'b1;
                        gap_d   = '0;
                        state_d = (GAP_CYC > 0) ? GAP : IDLE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        frame_d = {STOP_BIT, frame_q[FRAME_BITS-1:1]};
                        state_d = BIT_LO;
                    end
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; DONE follows the end-of-stop-bit flag by one cycle so it
    // lines up with the first GAP (or IDLE) cycle seen on the pins.
    always_comb begin
        sclk_d  = (state_q != BIT_LO);
        sdata_d = (state_q == BIT_LO || state_q == BIT_HI) ? frame_q[0] : 1'b1;
        busy_d  = (state_q != IDLE);
        done_d  = end_q;
`ifdef TX_FIFO_EN
        ready_d = ~fifo_full_next;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    assign SCLK     = sclk_q;
    assign SDATA    = sdata_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign TX_READY = ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx. Instance a uses CLK_DIV=4, FRAME_GAP=2;
// instance b uses CLK_DIV=1, FRAME_GAP=0. Frames are recovered by sampling SDATA
// on SCLK rising edges; expected frame vectors hold b0 at index 0.
module tb_serial_frame_tx;

`ifdef TX_FIFO_EN
    localparam int ACC_LAT = 2;
`else
    localparam int ACC_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_a = '0, data_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       ready_a, sclk_a, sdata_a, busy_a, done_a;
    logic       ready_b, sclk_b, sdata_b, busy_b, done_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_tx #(.CLK_DIV(4), .FRAME_GAP(2), .FIFO_DEPTH(4)) dut_a (
        .CLK(clk), .RST(rst), .TX_DATA(data_a), .TX_VALID(valid_a), .TX_READY(ready_a),
        .SCLK(sclk_a), .SDATA(sdata_a), .BUSY(busy_a), .DONE(done_a)
    );

    serial_frame_tx #(.CLK_DIV(1), .FRAME_GAP(0), .FIFO_DEPTH(4)) dut_b (
        .CLK(clk), .RST(rst), .TX_DATA(data_b), .TX_VALID(valid_b), .TX_READY(ready_b),
        .SCLK(sclk_b), .SDATA(sdata_b), .BUSY(busy_b), .DONE(done_b)
    );

    function automatic logic [7:0] decode(input logic [10:0] bits);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[7-i] = bits[1+i];
        return d;
    endfunction

    // Waits for TX_READY, presents one byte for one edge; acc_at = cycle of acceptance.
    task automatic send(input bit sel, input logic [7:0] d, output int acc_at, output bit ok);
        ok = 1'b0;
        acc_at = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ((sel ? ready_b : ready_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        if (sel) begin data_b = d; valid_b = 1'b1; end
        else     begin data_a = d; valid_a = 1'b1; end
        @(posedge clk);
        #1;
        acc_at = cyc;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    // Collects 11 bits at SCLK rising edges, then waits for DONE.
    task automatic capture(input bit sel, input int budget, output logic [10:0] bits,
                           output int fall_at, output int done_at, output bit ok);
        logic prev, sc, sd, dn;
        int nb;
        prev = 1'b1; nb = 0; fall_at = -1; done_at = -1; ok = 1'b0; bits = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            sc = sel ? sclk_b : sclk_a;
            sd = sel ? sdata_b : sdata_a;
            dn = sel ? done_b : done_a;
            if (prev && !sc && fall_at < 0) fall_at = cyc;
            if (!prev && sc && nb < 11) begin bits[nb] = sd; nb++; end
            prev = sc;
            if (dn === 1'b1 && nb == 11) begin done_at = cyc; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (sclk_a !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk_a); end
        checks++; if (sdata_a !== 1'b1) begin failures++; $display("FAIL reset_sdata got=%b exp=1", sdata_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_a); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", ready_a); end
        checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL ready_b_after_reset got=%b exp=1", ready_b); end
    endtask

    task automatic test_frame_a5();
        int acc, fall, dn, extra;
        bit ok;
        logic [10:0] bits;
        send(0, 8'hA5, acc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL a5_send timeout got=0 exp=1"); return; end
        capture(0, 200, bits, fall, dn, ok);
        checks++; if (!ok) begin failures++; $display("FAIL a5_capture timeout got=0 exp=1"); end
        checks++; if (bits !== 11'b11101001010) begin failures++; $display("FAIL a5_bits got=%b exp=%b", bits, 11'b11101001010); end
        checks++; if (fall - acc != ACC_LAT) begin failures++; $display("FAIL a5_latency got=%0d exp=%0d", fall - acc, ACC_LAT); end
        checks++; if (dn - fall != 88) begin failures++; $display("FAIL a5_done_time got=%0d exp=88", dn - fall); end
        extra = 0;
        repeat (40) begin @(negedge clk); if (done_a === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL a5_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_parity();
        int acc, fall, dn;
        bit ok;
        logic [10:0] bits;
        send(0, 8'h07, acc, ok);
        capture(0, 250, bits, fall, dn, ok);
        checks++; if (!ok) begin failures++; $display("FAIL p07_capture timeout got=0 exp=1"); end
        checks++; if (bits !== 11'b10111000000) begin failures++; $display("FAIL p07_bits got=%b exp=%b", bits, 11'b10111000000); end
        checks++; if (bits[9] !== 1'b0) begin failures++; $display("FAIL p07_parity got=%b exp=0", bits[9]); end
        checks++; if (decode(bits) !== 8'h07) begin failures++; $display("FAIL p07_code got=%h exp=07", decode(bits)); end
        send(0, 8'h00, acc, ok);
        capture(0, 250, bits, fall, dn, ok);
        checks++; if (!ok) begin failures++; $display("FAIL p00_capture timeout got=0 exp=1"); end
        checks++; if (bits !== 11'b11000000000) begin failures++; $display("FAIL p00_bits got=%b exp=%b", bits, 11'b11000000000); end
        checks++; if (bits[9] !== 1'b1) begin failures++; $display("FAIL p00_parity got=%b exp=1", bits[9]); end
        checks++; if (decode(bits) !== 8'h00) begin failures++; $display("FAIL p00_code got=%h exp=00", decode(bits)); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, lowcnt, fall, dn;
        bit ok, found;
        logic [10:0] bits;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ready_a === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL b2b_ready timeout got=0 exp=1"); return; end
        data_a = 8'h3C; valid_a = 1'b1;
        @(posedge clk); #1;
        a1 = cyc;
        data_a = 8'hC3;
        lowcnt = 0; found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready_a === 1'b1) begin found = 1'b1; break; end
            lowcnt++;
        end
        checks++; if (!found) begin failures++; $display("FAIL b2b_second timeout got=0 exp=1"); valid_a = 1'b0; return; end
        @(posedge clk); #1;
        a2 = cyc;
        valid_a = 1'b0;
        checks++; if (a2 - a1 != 105) begin failures++; $display("FAIL b2b_spacing got=%0d exp=105", a2 - a1); end
        checks++; if (lowcnt != 104) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=104", lowcnt); end
        capture(0, 200, bits, fall, dn, ok);
        checks++; if (bits !== 11'b11110000110) begin failures++; $display("FAIL b2b_bits got=%b exp=%b", bits, 11'b11110000110); end
        checks++; if (fall - a2 != 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", fall - a2); end
    endtask

    task automatic test_reset_mid();
        int acc, fall, dn, ndone, nlow;
        bit ok;
        logic [10:0] bits;
        send(0, 8'h5A, acc, ok);
        repeat (43) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy_a); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (sclk_a !== 1'b1) begin failures++; $display("FAIL rmid_sclk got=%b exp=1", sclk_a); end
        checks++; if (sdata_a !== 1'b1) begin failures++; $display("FAIL rmid_sdata got=%b exp=1", sdata_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy_a); end
        ndone = 0; nlow = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a === 1'b1) ndone++;
            if (sclk_a !== 1'b1) nlow++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL rmid_done got=%0d exp=0", ndone); end
        checks++; if (nlow != 0) begin failures++; $display("FAIL rmid_sclk_activity got=%0d exp=0", nlow); end
        send(0, 8'h3C, acc, ok);
        capture(0, 200, bits, fall, dn, ok);
        checks++; if (bits !== 11'b11001111000) begin failures++; $display("FAIL rmid_resend_bits got=%b exp=%b", bits, 11'b11001111000); end
        checks++; if (dn - fall != 88) begin failures++; $display("FAIL rmid_resend_time got=%0d exp=88", dn - fall); end
    endtask

    task automatic test_fast();
        int acc, bad, early;
        bit ok, fell;
        logic [10:0] bits;
        send(1, 8'hFF, acc, ok);
        fell = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sclk_b === 1'b0) begin fell = 1'b1; break; end
        end
        checks++; if (!fell) begin failures++; $display("FAIL fast_start timeout got=0 exp=1"); return; end
        bad = 0; early = 0; bits = '0;
        for (int i = 0; i < 22; i++) begin
            if (i > 0) @(negedge clk);
            if (sclk_b !== ((i % 2) == 1)) bad++;
            if (done_b === 1'b1) early++;
            if ((i % 2) == 1) bits[i/2] = sdata_b;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL fast_toggle got=%0d exp=0", bad); end
        checks++; if (early != 0) begin failures++; $display("FAIL fast_early_done got=%0d exp=0", early); end
        checks++; if (bits !== 11'b11111111110) begin failures++; $display("FAIL fast_bits got=%b exp=%b", bits, 11'b11111111110); end
        @(negedge clk);
        checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL fast_done got=%b exp=1", done_b); end
        checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL fast_ready got=%b exp=1", ready_b); end
        checks++; if (sclk_b !== 1'b1) begin failures++; $display("FAIL fast_idle_sclk got=%b exp=1", sclk_b); end
    endtask

`ifdef TX_FIFO_EN
    task automatic test_fifo();
        logic [5:0]  acc_flags;
        logic [10:0] bits;
        logic [7:0]  exp;
        int fall, dn, extra;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ready_a === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL fifo_ready timeout got=0 exp=1"); return; end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            data_a = 8'((k + 1) * 17);
            valid_a = 1'b1;
            acc_flags[k] = ready_a;
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
        checks++; if (acc_flags !== 6'b011111) begin failures++; $display("FAIL fifo_accept got=%b exp=%b", acc_flags, 6'b011111); end
        for (int j = 0; j < 5; j++) begin
            exp = 8'((j + 1) * 17);
            capture(0, 250, bits, fall, dn, ok);
            checks++; if (!ok || decode(bits) !== exp) begin failures++; $display("FAIL fifo_frame%0d got=%h exp=%h", j, decode(bits), exp); end
        end
        extra = 0;
        repeat (150) begin @(negedge clk); if (done_a === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL fifo_extra_done got=%0d exp=0", extra); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
`ifdef TX_FIFO_EN
        test_fifo();
`else
        test_back_to_back();
`endif
        test_reset_mid();
        test_fast();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
